uart_tx: RTL and testbench

- 8N1 UART transmitter for the SOC serial port: serializes bytes written by the CPU onto ftdi_txd. It is the transmit-side counterpart to the ftdi_rxd receive path.
- Sits between the memory-mapped IO decode (byte source) and the top-level ftdi_txd pin.
- Contains a one-entry holding register in front of the shift register, so back-to-back bytes go out with no idle gap between frames.

---
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-stream handshake and line outputs between the IO decode and the UART transmitter.
// The master drives bytes in; the slave (the transmitter) reports readiness, activity and the line.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       txd;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  txd
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output txd
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register ahead of the shifter,
// so a queued byte starts its frame right after the previous stop bit.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  uart_tx_if.slave   bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [CW-1:0] baud_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;
  logic          txd_q;
  logic          bit_end;
  logic          accept;

  assign bit_end = (baud_q == LAST_TICK);
  assign baud_d  = bit_end ? '0 : baud_q + CW'(1);
  assign accept  = bus.tx_valid && !hold_full_q;

  // Accept and transfer never coincide: accept needs an empty holder, transfer a full one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      if (accept) begin
        hold_q      <= bus.tx_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b0;
            state_q     <= START;
          end
        end

        START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            txd_q   <= shift_q[0];
            bit_q   <= '0;
            state_q <= DATA;
          end
        end

        DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              txd_q <= shift_q[1];
            end
          end
        end

        STOP: begin
          baud_q <= baud_d;
          if (bit_end) begin
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              txd_q       <= 1'b0;
              state_q     <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = !hold_full_q;
  assign bus.busy     = (state_q != IDLE) || hold_full_q;
  assign bus.txd      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a 16-clocks-per-bit instance for the detailed line checks
// and a default-rate instance for the 115200 baud decode.
module tb_uart_tx;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  logic       tbValid [2];
  logic [7:0] tbData  [2];
  logic       obsTxd  [2];
  logic       obsReady[2];
  logic       obsBusy [2];

  uart_tx_if ifA ();
  uart_tx_if ifB ();

  assign ifA.tx_valid = tbValid[0];
  assign ifA.tx_data  = tbData[0];
  assign ifB.tx_valid = tbValid[1];
  assign ifB.tx_data  = tbData[1];
  assign obsTxd[0]    = ifA.txd;
  assign obsTxd[1]    = ifB.txd;
  assign obsReady[0]  = ifA.tx_ready;
  assign obsReady[1]  = ifB.tx_ready;
  assign obsBusy[0]   = ifA.busy;
  assign obsBusy[1]   = ifB.busy;

  uart_tx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) dutA (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifA.slave)
  );

  uart_tx dutB (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; presents a byte for exactly one rising edge.
  task automatic applyStimulus(input int s, input logic [7:0] d, input string tag);
    checkOutput({tag, " ready before"}, 32'(obsReady[s]), 32'd1);
    tbValid[s] = 1'b1;
    tbData[s]  = d;
    @(negedge clk);
    tbValid[s] = 1'b0;
    checkOutput({tag, " ready after accept"}, 32'(obsReady[s]), 32'd0);
    checkOutput({tag, " busy after accept"}, 32'(obsBusy[s]), 32'd1);
  endtask

  // Waits for a start bit, then checks every cycle of all ten bit slots against the
  // expected frame; optionally queues another byte during bit injBit.
  task automatic checkFrame(input int s, input logic [7:0] expData, input string tag,
                            input int maxWait, input int injBit, input logic [7:0] injData,
                            input int ffCycles, output int busyCnt);
    int cpb;
    int waited;
    int bad;
    int ffLeft;
    logic expBit;
    logic [9:0] frame;
    logic [7:0] decoded;
    cpb     = s ? 217 : 16;
    frame   = {1'b1, expData, 1'b0};
    decoded = '0;
    busyCnt = 0;
    waited  = 0;
    ffLeft  = 0;
    while (obsTxd[s] !== 1'b0 && waited < maxWait) begin
      if (obsBusy[s] === 1'b1) busyCnt++;
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " start seen"}, 32'(obsTxd[s]), 32'd0);
    for (int b = 0; b < 10; b++) begin
      bad    = 0;
      expBit = frame[b];
      for (int c = 0; c < cpb; c++) begin
        if (obsTxd[s] !== expBit) bad++;
        if (obsBusy[s] === 1'b1) busyCnt++;
        if (b >= 1 && b <= 8 && c == cpb / 2) decoded[b-1] = obsTxd[s];
        if (b == injBit && c == 0) begin
          tbValid[s] = 1'b1;
          tbData[s]  = injData;
        end else if (b == injBit && c == 1) begin
          if (ffCycles > 0) begin
            tbData[s] = 8'hFF;
            ffLeft    = ffCycles;
          end else begin
            tbValid[s] = 1'b0;
          end
        end else if (ffLeft > 0) begin
          ffLeft--;
          if (ffLeft == 0) tbValid[s] = 1'b0;
        end
        if (b == injBit && c == 2)
          checkOutput({tag, " ready while holding"}, 32'(obsReady[s]), 32'd0);
        @(negedge clk);
      end
      checkOutput($sformatf("%s bit%0d wrong cycles", tag, b), 32'(bad), 32'd0);
    end
    checkOutput({tag, " decoded"}, 32'(decoded), 32'(expData));
  endtask

  initial begin
    int busyCnt;
    int bad;
    int waited;
    checks     = 0;
    errors     = 0;
    tbValid[0] = 1'b0;
    tbValid[1] = 1'b0;
    tbData[0]  = 8'h00;
    tbData[1]  = 8'h00;
    resetn     = 1'b1;

    // Asynchronous reset, observed before any clock edge
    #3 resetn = 1'b0;
    #1;
    checkOutput("reset txd", 32'(obsTxd[0]), 32'd1);
    checkOutput("reset ready", 32'(obsReady[0]), 32'd1);
    checkOutput("reset busy", 32'(obsBusy[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle txd", 32'(obsTxd[0]), 32'd1);
    checkOutput("idle txd default", 32'(obsTxd[1]), 32'd1);

    // Single byte 0x55
    applyStimulus(0, 8'h55, "single");
    checkOutput("single txd before load", 32'(obsTxd[0]), 32'd1);
    checkFrame(0, 8'h55, "single", 4, -1, 8'h00, 0, busyCnt);
    checkOutput("single busy cycles", 32'(busyCnt), 32'd161);
    checkOutput("single busy after", 32'(obsBusy[0]), 32'd0);
    checkOutput("single txd after", 32'(obsTxd[0]), 32'd1);
    repeat (5) @(negedge clk);

    // Back-to-back 0xA5 then 0x3C with no gap
    applyStimulus(0, 8'hA5, "b2b");
    checkFrame(0, 8'hA5, "b2b first", 4, 2, 8'h3C, 0, busyCnt);
    checkFrame(0, 8'h3C, "b2b second", 0, -1, 8'h00, 0, busyCnt);
    checkOutput("b2b second busy", 32'(busyCnt), 32'd160);
    checkOutput("b2b idle after", 32'(obsBusy[0]), 32'd0);
    repeat (5) @(negedge clk);

    // Backpressure: 0x12 on the line, 0x34 held, 0xFF offered for 50 cycles and ignored
    applyStimulus(0, 8'h12, "bp");
    checkFrame(0, 8'h12, "bp first", 4, 1, 8'h34, 50, busyCnt);
    checkFrame(0, 8'h34, "bp second", 0, -1, 8'h00, 0, busyCnt);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (obsTxd[0] !== 1'b1 || obsBusy[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput("bp no duplicate frame", 32'(bad), 32'd0);
    checkOutput("bp ready at end", 32'(obsReady[0]), 32'd1);

    // Reset during data bit 3 of 0x0F, then a clean 0x81
    applyStimulus(0, 8'h0F, "midrst");
    waited = 0;
    while (obsTxd[0] !== 1'b0 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midrst start seen", 32'(obsTxd[0]), 32'd0);
    repeat (16 * 4 + 8) @(negedge clk);
    checkOutput("midrst busy in bit3", 32'(obsBusy[0]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midrst txd", 32'(obsTxd[0]), 32'd1);
    checkOutput("midrst busy", 32'(obsBusy[0]), 32'd0);
    checkOutput("midrst ready", 32'(obsReady[0]), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (obsTxd[0] !== 1'b1) bad++;
    end
    checkOutput("midrst txd held high", 32'(bad), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(0, 8'h81, "after rst");
    checkFrame(0, 8'h81, "after rst", 4, -1, 8'h00, 0, busyCnt);
    checkOutput("after rst busy cycles", 32'(busyCnt), 32'd161);

    // Default rate: 217 clocks per bit, 'A'
    applyStimulus(1, 8'h41, "default");
    checkFrame(1, 8'h41, "default", 4, -1, 8'h00, 0, busyCnt);
    checkOutput("default busy cycles", 32'(busyCnt), 32'd2171);
    checkOutput("default idle after", 32'(obsBusy[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
